// File: rtl/l1_d_data_array.sv
// rtl/l1_d_data_array.sv - L1 D-cache data store with store merge, load alignment and L2 line exchange.
// Optional per-byte even parity is enabled with L1D_PARITY_EN.
module l1_d_data_array #(
    parameter int SETS      = 32,
    parameter int LINE_BITS = 512,
    parameter int WORD_BITS = 32
) (
    input  logic                     clk,
    input  logic                     nrst,
    input  logic [$clog2(SETS)-1:0]  index_C_L1,
    input  logic [5:0]               offset_C_L1,
    input  logic [1:0]               size_C_L1,
    input  logic                     unsigned_C_L1,
    input  logic                     read_C_L1,
    input  logic                     write_C_L1,
    input  logic [WORD_BITS-1:0]     write_data_C_L1,
    input  logic                     stall,
    input  logic                     way,
    input  logic                     refill,
    input  logic                     update,
    input  logic                     write_L1_L2,
    input  logic [LINE_BITS-1:0]     read_data_L2_L1,
    output logic [LINE_BITS-1:0]     write_data_L1_L2,
    output logic [WORD_BITS-1:0]     read_data_C_L1,
    output logic                     read_valid_C_L1,
    output logic                     misalign_o,
    output logic                     parity_err_o
);
    localparam int IDX_W = $clog2(SETS);
    localparam int SLOTS = 2 * SETS;
    localparam int BYTES = LINE_BITS / 8;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [LINE_BITS-1:0]   data_q [SLOTS];
    logic [IDX_W:0]         slot;
    logic [LINE_BITS-1:0]   cur_line, line_new;
    logic [BYTES-1:0]       upd_be;
    logic                   req, misaligned;
    logic [3:0]             st_be;
    logic [WORD_BITS-1:0]   st_data, word_sel, shifted, load_val;
    logic                   load_perr;

    logic                   op_read_q, op_read_d;
    logic [5:0]             ld_off_q, ld_off_d;
    logic [1:0]             ld_size_q, ld_size_d;
    logic                   ld_uns_q, ld_uns_d;
    logic [3:0]             st_word_q, st_word_d;
    logic [3:0]             be_q, be_d;
    logic [WORD_BITS-1:0]   wdata_q, wdata_d;
    logic                   mis_hold_q, mis_hold_d;
    logic                   misalign_q, misalign_d;
    logic [WORD_BITS-1:0]   rdata_q, rdata_d;
    logic                   rvalid_q, rvalid_d;
    logic                   perr_q, perr_d;
    logic                   wl2_q;
    logic [LINE_BITS-1:0]   wb_q;

    assign slot     = {index_C_L1, way};
    assign cur_line = data_q[slot];
    assign req      = read_C_L1 | write_C_L1;
    assign misaligned = (size_C_L1 == 2'b11) ||
                        (size_C_L1 == 2'b01 && offset_C_L1[0]) ||
                        (size_C_L1 == 2'b10 && offset_C_L1[1:0] != 2'b00);

    // Store data is replicated so every enabled lane sees its own byte.
    always_comb begin
        st_be   = 4'hF;
        st_data = write_data_C_L1;
        case (size_C_L1)
            2'b00: begin
                st_be   = 4'b0001 << offset_C_L1[1:0];
                st_data = {4{write_data_C_L1[7:0]}};
            end
            2'b01: begin
                st_be   = 4'b0011 << {offset_C_L1[1], 1'b0};
                st_data = {2{write_data_C_L1[15:0]}};
            end
            default: ;
        endcase
    end

    assign word_sel = cur_line[ld_off_q[5:2]*WORD_BITS +: WORD_BITS];
    assign shifted  = word_sel >> {ld_off_q[1:0], 3'b000};

    always_comb begin
        load_val = shifted;
        case (ld_size_q)
            2'b00: load_val = ld_uns_q ? {{(WORD_BITS-8){1'b0}}, shifted[7:0]}
                                       : {{(WORD_BITS-8){shifted[7]}}, shifted[7:0]};
            2'b01: load_val = ld_uns_q ? {{(WORD_BITS-16){1'b0}}, shifted[15:0]}
                                       : {{(WORD_BITS-16){shifted[15]}}, shifted[15:0]};
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_read_d  = op_read_q;
        ld_off_d   = ld_off_q;
        ld_size_d  = ld_size_q;
        ld_uns_d   = ld_uns_q;
        st_word_d  = st_word_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        rvalid_d   = 1'b0;
        perr_d     = 1'b0;
        misalign_d = 1'b0;
        mis_hold_d = (state_q == S_IDLE) && req && misaligned;
        case (state_q)
            S_IDLE: begin
                if (req && misaligned) begin
                    // Pulse once per held request; drop any stale pending store.
                    misalign_d = !mis_hold_q;
                    be_d       = 4'h0;
                end else if (req) begin
                    state_d   = S_BUSY;
                    op_read_d = read_C_L1;
                    ld_off_d  = offset_C_L1;
                    ld_size_d = size_C_L1;
                    ld_uns_d  = unsigned_C_L1;
                    if (!read_C_L1) begin
                        st_word_d = offset_C_L1[5:2];
                        be_d      = st_be;
                        wdata_d   = st_data;
                    end
                end
            end
            S_BUSY: if (!stall) state_d = S_DONE;
            S_DONE: begin
                state_d = S_IDLE;
                if (op_read_q) begin
                    rdata_d  = load_val;
                    rvalid_d = 1'b1;
                    perr_d   = load_perr;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Refill data is the base; pending store bytes override it in the same write.
    assign upd_be = update ? (BYTES'(be_q) << {st_word_q, 2'b00}) : '0;

    always_comb begin
        line_new = cur_line;
        for (int b = 0; b < BYTES; b++) begin
            if (upd_be[b])
                line_new[8*b +: 8] = wdata_q[8*(b%4) +: 8];
            else if (refill)
                line_new[8*b +: 8] = read_data_L2_L1[8*b +: 8];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < SLOTS; i++) data_q[i] <= '0;
        end else if (refill || update) begin
            data_q[slot] <= line_new;
        end
    end

`ifdef L1D_PARITY_EN
    logic [BYTES-1:0] par_q [SLOTS];
    logic [BYTES-1:0] par_new;
    logic [3:0]       par_chk;

    always_comb begin
        par_new = par_q[slot];
        for (int b = 0; b < BYTES; b++)
            if (refill || upd_be[b]) par_new[b] = ^line_new[8*b +: 8];
        for (int i = 0; i < 4; i++) par_chk[i] = ^word_sel[8*i +: 8];
    end

    assign load_perr = |(par_chk ^ par_q[slot][ld_off_q[5:2]*4 +: 4]);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int i = 0; i < SLOTS; i++) par_q[i] <= '0;
        end else if (refill || update) begin
            par_q[slot] <= par_new;
        end
    end
`else
    assign load_perr = 1'b0;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            op_read_q  <= 1'b0;
            ld_off_q   <= '0;
            ld_size_q  <= '0;
            ld_uns_q   <= 1'b0;
            st_word_q  <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            mis_hold_q <= 1'b0;
            misalign_q <= 1'b0;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            perr_q     <= 1'b0;
            wl2_q      <= 1'b0;
            wb_q       <= '0;
        end else begin
            state_q    <= state_d;
            op_read_q  <= op_read_d;
            ld_off_q   <= ld_off_d;
            ld_size_q  <= ld_size_d;
            ld_uns_q   <= ld_uns_d;
            st_word_q  <= st_word_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            mis_hold_q <= mis_hold_d;
            misalign_q <= misalign_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            perr_q     <= perr_d;
            wl2_q      <= write_L1_L2;
            // Victim is frozen until the next rising strobe.
            if (write_L1_L2 && !wl2_q) wb_q <= cur_line;
        end
    end

    assign write_data_L1_L2 = wb_q;
    assign read_data_C_L1   = rdata_q;
    assign read_valid_C_L1  = rvalid_q;
    assign misalign_o       = misalign_q;
    assign parity_err_o     = perr_q;
endmodule

// File: doc/l1_d_data_array.md
Name: l1_d_data_array

Overview:
- Data store and alignment stage directly downstream of the L1 D-cache controller.
- 32 sets x 2 ways, 64-byte lines (addr = tag[31:11], index[10:6], offset[5:0]).
- Consumes controller strobes refill/update/way and returns aligned load data to the core.
- Exchanges full 512-bit lines with L2 for refill and write-back.

Parameters:
- SETS, 32, number of sets; index width = log2(SETS) = 5
- LINE_BITS, 512, line width in bits (64 bytes)
- WORD_BITS, 32, core data width

Ports:
- clk  input  1  system clock
- nrst  input  1  asynchronous active-low reset
- index_C_L1  input  5  set index from core address [10:6]
- offset_C_L1  input  6  byte offset from core address [5:0]
- size_C_L1  input  2  access size: 00 byte, 01 half, 10 word, 11 reserved
- unsigned_C_L1  input  1  load zero-extend when 1, sign-extend when 0
- read_C_L1  input  1  core load request, held until stall deasserts
- write_C_L1  input  1  core store request, held until stall deasserts
- write_data_C_L1  input  32  store data, right-aligned
- stall  input  1  controller busy
- way  input  1  way selected by controller
- refill  input  1  one-cycle pulse: write refill line into {index,way}
- update  input  1  one-cycle pulse: merge pending store into {index,way}
- write_L1_L2  input  1  controller write-back strobe
- read_data_L2_L1  input  512  refill line from L2, valid while refill=1
- write_data_L1_L2  output  512  victim line to L2
- read_data_C_L1  output  32  aligned load result
- read_valid_C_L1  output  1  one-cycle pulse, load result valid
- misalign_o  output  1  one-cycle pulse on a misaligned or reserved-size access
- parity_err_o  output  1  parity error pulse (feature only; tied 0 otherwise)

Behaviour:
- Reset: all outputs 0; data array contents 0; pending-store register cleared; internal FSM to S_IDLE.
- Storage: 64 lines addressed by {index,way}. Clocked writes only; reads are combinational into output registers.
- Store capture:
  - On the first cycle of write_C_L1 (S_IDLE), latch data, offset and size into the pending-store register.
  - Byte enables are computed from offset[1:0] and size; data is replicated to the target lanes.
- FSM states: S_IDLE, S_BUSY, S_DONE.
  - S_IDLE -> S_BUSY on read_C_L1 or write_C_L1, provided the access is aligned.
  - S_BUSY -> S_DONE when stall falls.
  - S_DONE -> S_IDLE after 1 cycle.
- update=1: merge pending store bytes into line[{index,way}] word offset[5:2]; other bytes are unchanged.
- refill=1: overwrite the whole line with read_data_L2_L1.
  - If refill and update coincide, the refill is applied first and the store bytes then override it in the same write.
- Load:
  - In S_DONE for a read, register the word at offset[5:2] of line[{index,way}].
  - Shift by offset[1:0], select by size, extend per unsigned_C_L1.
  - Drive read_data_C_L1 and pulse read_valid_C_L1 in the cycle after S_DONE: 2 cycles after stall falls.
  - read_data_C_L1 holds its value until the next load.
- Write-back: on the rising edge of write_L1_L2, capture line[{index,way}] into write_data_L1_L2. Hold it until the next rising edge, so a later refill of the same line does not corrupt the victim.
- Misalignment:
  - A half access with offset[0]=1, a word access with offset[1:0]!=0, or size=11 pulses misalign_o for 1 cycle.
  - The FSM stays in S_IDLE, no pending store is latched, and any later update for that request writes nothing (byte enables 0).
- Reset mid-operation: FSM returns to S_IDLE, pending store is discarded, read_valid_C_L1 is not pulsed.
- Array contents are not affected by flush (validity is owned by the controller).

Optional Feature:
- Macro: L1D_PARITY_EN.
- Defined:
  - An even-parity bit is stored per byte (64 per line), written on refill and on update for the enabled bytes.
  - On a load, the 4 bytes of the selected word are checked. parity_err_o pulses alongside read_valid_C_L1 if any parity mismatches; data is still returned.
  - Write-back line parity is not checked.
- Undefined: no parity storage; parity_err_o tied to 0.

Test Plan:
- Refill index 3 way 1 with line bytes 0x00..0x3F; load word, offset 0x08, signed -> read_data_C_L1 = 0x0B0A0908, read_valid_C_L1 one cycle, 2 cycles after stall falls.
- Same line: store byte 0xA5 at offset 0x11, update pulse; load signed byte at 0x11 -> 0xFFFFFFA5; unsigned -> 0x000000A5; word at 0x10 -> 0x1312A510.
- Load half with offset 0x03 -> misalign_o pulse, no read_valid_C_L1; a later update pulse leaves the line unchanged.
- Fill index 5 way 0 with 0xDEAD...; write_L1_L2 rise, then refill the same slot with 0x1234... -> write_data_L1_L2 stays 0xDEAD... .
- Refill and update in the same cycle with a word store 0xCAFEF00D at 0x04 -> word 1 = 0xCAFEF00D, other words equal the refill data.
- With L1D_PARITY_EN, force-flip one stored bit of byte 0x08, then load word at 0x08 -> parity_err_o pulses with read_valid_C_L1. Without the macro -> parity_err_o stays 0.
